tdm_demux_rx: RTL and testbench

//  - Receive end of a time-division-multiplexed word stream: one W-bit beat per slot, N_CH slots per frame.
//  - Routes each accepted beat to its channel's output register and flags frame completion and sync loss.
//  - Sits after a shared-link mux stage and feeds per-channel consumers.

---
 rtl/tdm_demux_rx.sv | 86 ++++++++
 tb/tb_tdm_demux_rx.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_rx.sv
// TDM receive demultiplexer: routes each slot's beat to its channel register, tracks frame alignment.
// Optional even-parity checking on each beat is enabled by defining TDM_DEMUX_RX_PARITY_EN.
module tdm_demux_rx #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [W-1:0]      in_data,
    input  logic              in_first,
`ifdef TDM_DEMUX_RX_PARITY_EN
    input  logic              in_parity,
    output logic              par_err,
`endif
    output logic [N_CH*W-1:0] out_data,
    output logic [N_CH-1:0]   out_valid,
    output logic              frame_done,
    output logic              locked,
    output logic              sync_err
);

    localparam int unsigned SW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [SW-1:0] LAST = SW'(N_CH - 1);

    typedef enum logic {HUNT, LOCK} state_t;

    state_t        state;
    logic [SW-1:0] slot;
    logic [SW-1:0] dst_c;
    logic [SW-1:0] nxt_c;
    logic          good_c;

    // A first-marked beat always lands in ch0; otherwise the current slot.
    always_comb begin
        dst_c = in_first ? '0 : slot;
        nxt_c = (dst_c == LAST) ? '0 : dst_c + SW'(1);
`ifdef TDM_DEMUX_RX_PARITY_EN
        good_c = ((^in_data) ^ in_parity) == 1'b0;
`else
        good_c = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            slot       <= '0;
            out_data   <= '0;
            out_valid  <= '0;
            frame_done <= 1'b0;
            locked     <= 1'b0;
            sync_err   <= 1'b0;
`ifdef TDM_DEMUX_RX_PARITY_EN
            par_err    <= 1'b0;
`endif
        end else begin
            out_valid  <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
`ifdef TDM_DEMUX_RX_PARITY_EN
            par_err    <= 1'b0;
`endif
            // Beats are only accepted once aligned, or when they carry the frame marker.
            if (in_valid && (state == LOCK || in_first)) begin
                state  <= LOCK;
                locked <= 1'b1;
                slot   <= nxt_c;
                if (state == LOCK && in_first && slot != '0) begin
                    sync_err <= 1'b1;
                end
                if (good_c) begin
                    out_data[dst_c*W +: W] <= in_data;
                    out_valid[dst_c]       <= 1'b1;
                    frame_done             <= (dst_c == LAST);
                end
`ifdef TDM_DEMUX_RX_PARITY_EN
                else begin
                    par_err <= 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Directed bench for tdm_demux_rx (N_CH=4, W=8); parity checks run when TDM_DEMUX_RX_PARITY_EN is defined.
module tb_tdm_demux_rx;

    localparam int unsigned N_CH = 4;
    localparam int unsigned W    = 8;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [W-1:0]      in_data;
    logic              in_first;
    logic              in_parity;
    logic [N_CH*W-1:0] out_data;
    logic [N_CH-1:0]   out_valid;
    logic              frame_done;
    logic              locked;
    logic              sync_err;
`ifdef TDM_DEMUX_RX_PARITY_EN
    logic              par_err;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    tdm_demux_rx #(.N_CH(N_CH), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_first   (in_first),
`ifdef TDM_DEMUX_RX_PARITY_EN
        .in_parity  (in_parity),
        .par_err    (par_err),
`endif
        .out_data   (out_data),
        .out_valid  (out_valid),
        .frame_done (frame_done),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock with the given beat; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic v, input logic f, input logic [W-1:0] d, input logic bad = 1'b0);
        in_valid  = v;
        in_first  = f;
        in_data   = d;
        in_parity = (^d) ^ bad;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic chk_pulses(input string tag, input logic [N_CH-1:0] ov, input logic fd, input logic se);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
        check({tag, ".frame_done"}, 64'(frame_done), 64'(fd));
        check({tag, ".sync_err"}, 64'(sync_err), 64'(se));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_data = '0; in_parity = 1'b0;
        @(posedge clk); #1;
        cyc(0, 0, 8'h00);
        rst = 1'b0;
        check("reset.out_data", 64'(out_data), 64'h0);
        check("reset.locked", 64'(locked), 64'h0);
        chk_pulses("reset", 4'b0000, 0, 0);

        // Hunting: non-first beats dropped
        cyc(1, 0, 8'h11);
        chk_pulses("hunt0", 4'b0000, 0, 0);
        cyc(1, 0, 8'h22);
        check("hunt1.locked", 64'(locked), 64'h0);
        check("hunt1.out_data", 64'(out_data), 64'h0);

        // Acquire and fill one frame
        cyc(1, 1, 8'hA0);
        chk_pulses("f0s0", 4'b0001, 0, 0);
        check("f0s0.locked", 64'(locked), 64'h1);
        check("f0s0.out_data", 64'(out_data), 64'h0000_00A0);
        cyc(1, 0, 8'hA1);
        chk_pulses("f0s1", 4'b0010, 0, 0);
        cyc(1, 0, 8'hA2);
        chk_pulses("f0s2", 4'b0100, 0, 0);
        cyc(1, 0, 8'hA3);
        chk_pulses("f0s3", 4'b1000, 1, 0);
        check("f0s3.out_data", 64'(out_data), 64'hA3A2_A1A0);
        cyc(0, 0, 8'hFF);
        chk_pulses("idle", 4'b0000, 0, 0);
        check("idle.out_data", 64'(out_data), 64'hA3A2_A1A0);

        // Free-run frame without marker, then resync after two beats
        cyc(1, 0, 8'hB0);
        chk_pulses("fr0", 4'b0001, 0, 0);
        cyc(1, 0, 8'hB1);
        chk_pulses("fr1", 4'b0010, 0, 0);
        cyc(1, 1, 8'h55);
        chk_pulses("resync", 4'b0001, 0, 1);
        check("resync.out_data", 64'(out_data), 64'hA3A2_B155);
        check("resync.locked", 64'(locked), 64'h1);
        cyc(1, 0, 8'h66);
        chk_pulses("resync1", 4'b0010, 0, 0);
        check("resync1.out_data", 64'(out_data), 64'hA3A2_6655);
        cyc(1, 0, 8'h77);
        cyc(1, 0, 8'h88);
        chk_pulses("resync3", 4'b1000, 1, 0);
        check("resync3.out_data", 64'(out_data), 64'h8877_6655);

        // Gapped frame: slot holds through idle cycles
        for (int i = 0; i < N_CH; i++) begin
            cyc(1, (i == 0), 8'(8'hC0 + i));
            chk_pulses($sformatf("gap%0d", i), 4'(1 << i), (i == N_CH - 1), 0);
            cyc(0, 0, 8'h5A);
            chk_pulses($sformatf("gapidle%0d", i), 4'b0000, 0, 0);
        end
        check("gap.out_data", 64'(out_data), 64'hC3C2_C1C0);

        // Reset mid-frame discards alignment
        cyc(1, 1, 8'hD0);
        cyc(1, 0, 8'hD1);
        cyc(1, 0, 8'hD2);
        check("pre_rst.out_data", 64'(out_data), 64'hC3D2_D1D0);
        rst = 1'b1;
        cyc(1, 0, 8'hD3);
        rst = 1'b0;
        check("rst.out_data", 64'(out_data), 64'h0);
        check("rst.locked", 64'(locked), 64'h0);
        chk_pulses("rst", 4'b0000, 0, 0);
        cyc(1, 0, 8'hE0);
        check("post_rst.locked", 64'(locked), 64'h0);
        check("post_rst.out_data", 64'(out_data), 64'h0);
        chk_pulses("post_rst", 4'b0000, 0, 0);

`ifdef TDM_DEMUX_RX_PARITY_EN
        // Bad parity beat at slot 1: not written, slot still advances
        cyc(1, 1, 8'hF0);
        check("par0.par_err", 64'(par_err), 64'h0);
        cyc(1, 0, 8'h03, 1'b1);
        check("par1.par_err", 64'(par_err), 64'h1);
        chk_pulses("par1", 4'b0000, 0, 0);
        check("par1.out_data", 64'(out_data), 64'h0000_00F0);
        cyc(1, 0, 8'hF2);
        check("par2.par_err", 64'(par_err), 64'h0);
        chk_pulses("par2", 4'b0100, 0, 0);
        check("par2.out_data", 64'(out_data), 64'h00F2_00F0);
        cyc(1, 0, 8'hF3, 1'b1);
        check("par3.par_err", 64'(par_err), 64'h1);
        chk_pulses("par3", 4'b0000, 0, 0);
        // Bad marker beat while hunting still locks
        rst = 1'b1;
        cyc(0, 0, 8'h00);
        rst = 1'b0;
        cyc(1, 1, 8'h01, 1'b1);
        check("parhunt.locked", 64'(locked), 64'h1);
        check("parhunt.par_err", 64'(par_err), 64'h1);
        check("parhunt.out_data", 64'(out_data), 64'h0);
        cyc(1, 0, 8'h44);
        chk_pulses("parhunt1", 4'b0010, 0, 0);
        check("parhunt1.out_data", 64'(out_data), 64'h0000_4400);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
